// File: rtl/otl_trx_pkg.sv
// Shared types and constants for the transceiver register-bus router.
package otl_trx_pkg;

  typedef enum logic {
    W_IDLE,
    W_FWD
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_WAIT,
    R_RSP
  } rd_state_t;

  // Bit positions inside err_status
  localparam int ERR_DEC = 0;
  localparam int ERR_TMO = 1;

  localparam logic [31:0] ERRDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/otl_trx_decode.sv
// Address decoder: extracts the target-select field and flags whether it
// addresses an existing target.
module otl_trx_decode
  import otl_trx_pkg::*;
#(
  parameter int ADDRW  = 12,
  parameter int SELLSB = 9,
  parameter int SELW   = 3,
  parameter int NTGT   = 4
) (
  input  logic [ADDRW-1:0] addr,
  output logic [SELW-1:0]  sel,
  output logic             mapped
);

  // Bits outside the select field are intentionally ignored here
  logic unused_addr;
  assign unused_addr = ^addr;

  assign sel    = addr[SELLSB+SELW-1:SELLSB];
  assign mapped = (32'(sel) < NTGT);

endmodule

// File: rtl/otl_trx_router.sv
// Register-bus router: one core-side register port fanned out to NTGT
// targets through registered valid/ready handshakes. Independent write and
// read FSMs; unmapped accesses are answered locally with an error.
// Optional feature macro: OTL_TRX_ROUTER_TIMEOUT_EN (read timeout counter).
module otl_trx_router
  import otl_trx_pkg::*;
#(
  parameter int ADDRW   = 12,
  parameter int DATAW   = 32,
  parameter int NTGT    = 4,
  parameter int SELLSB  = 9,
  parameter int SELW    = 3,
  parameter int TIMEOUT = 255,
  parameter logic [DATAW-1:0] ERRDATA = DATAW'(ERRDATA_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATAW-1:0]      s_wrdata,
  input  logic [ADDRW-1:0]      s_wraddr,
  input  logic                  s_wrvalid,
  output logic                  s_wrready,
  input  logic [ADDRW-1:0]      s_rdaddr,
  input  logic                  s_rdaddrvalid,
  output logic                  s_rdaddrready,
  output logic [DATAW-1:0]      s_rddata,
  output logic                  s_rdvalid,
  input  logic                  s_rdready,
  output logic [NTGT*DATAW-1:0] m_wrdata,
  output logic [NTGT*ADDRW-1:0] m_wraddr,
  output logic [NTGT-1:0]       m_wrvalid,
  input  logic [NTGT-1:0]       m_wrready,
  output logic [NTGT*ADDRW-1:0] m_rdaddr,
  output logic [NTGT-1:0]       m_rdaddrvalid,
  input  logic [NTGT-1:0]       m_rdaddrready,
  input  logic [NTGT*DATAW-1:0] m_rddata,
  input  logic [NTGT-1:0]       m_rdvalid,
  output logic [NTGT-1:0]       m_rdready,
  output logic [1:0]            err_status,
  input  logic                  err_clr
);

  localparam int IDXW = (NTGT > 1) ? $clog2(NTGT) : 1;

  logic [SELW-1:0]  wr_sel;
  logic [SELW-1:0]  rd_sel;
  logic             wr_mapped;
  logic             rd_mapped;
  logic             wr_acc;
  logic             rd_acc;
  logic             dec_err;
  logic             tmo_hit;

  wr_state_t        wr_state;
  logic [ADDRW-1:0] wr_addr_q;
  logic [DATAW-1:0] wr_data_q;
  logic [IDXW-1:0]  wr_idx;

  rd_state_t        rd_state;
  logic [ADDRW-1:0] rd_addr_q;
  logic [IDXW-1:0]  rd_idx;
  logic [DATAW-1:0] rd_slice [NTGT];

  otl_trx_decode #(
    .ADDRW (ADDRW),
    .SELLSB(SELLSB),
    .SELW  (SELW),
    .NTGT  (NTGT)
  ) u_wr_dec (
    .addr  (s_wraddr),
    .sel   (wr_sel),
    .mapped(wr_mapped)
  );

  otl_trx_decode #(
    .ADDRW (ADDRW),
    .SELLSB(SELLSB),
    .SELW  (SELW),
    .NTGT  (NTGT)
  ) u_rd_dec (
    .addr  (s_rdaddr),
    .sel   (rd_sel),
    .mapped(rd_mapped)
  );

  assign wr_acc  = s_wrready & s_wrvalid;
  assign rd_acc  = s_rdaddrready & s_rdaddrvalid;
  assign dec_err = (wr_acc & ~wr_mapped) | (rd_acc & ~rd_mapped);

  // Address/data go to every target slice; only the selected valid is raised
  assign m_wrdata = {NTGT{wr_data_q}};
  assign m_wraddr = {NTGT{wr_addr_q}};
  assign m_rdaddr = {NTGT{rd_addr_q}};

  for (genvar g = 0; g < NTGT; g++) begin : g_slice
    assign rd_slice[g] = m_rddata[g*DATAW +: DATAW];
  end

`ifdef OTL_TRX_ROUTER_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);
  logic [CNTW-1:0] tmo_cnt;

  // Fires only when the outstanding phase would otherwise stall this cycle
  assign tmo_hit = (tmo_cnt == CNTW'(TIMEOUT - 1)) &&
                   (((rd_state == R_REQ)  && !m_rdaddrready[rd_idx]) ||
                    ((rd_state == R_WAIT) && !m_rdvalid[rd_idx]));

  // Cycle counter: held at zero while idle so it starts fresh on R_REQ entry
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (rd_state == R_REQ || rd_state == R_WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT;
  assign tmo_hit    = 1'b0;
`endif

  // Write payload capture on every accepted write
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      wr_addr_q <= s_wraddr;
      wr_data_q <= s_wrdata;
      wr_idx    <= wr_sel[IDXW-1:0];
    end
  end

  // Write FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state  <= W_IDLE;
      s_wrready <= 1'b0;
      m_wrvalid <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (wr_acc) begin
            if (wr_mapped) begin
              wr_state  <= W_FWD;
              s_wrready <= 1'b0;
              m_wrvalid <= NTGT'(1) << wr_sel[IDXW-1:0];
            end
          end else begin
            s_wrready <= 1'b1;
          end
        end
        W_FWD: begin
          if (m_wrready[wr_idx]) begin
            wr_state  <= W_IDLE;
            s_wrready <= 1'b1;
            m_wrvalid <= '0;
          end
        end
        default: begin
          wr_state  <= W_IDLE;
          s_wrready <= 1'b0;
          m_wrvalid <= '0;
        end
      endcase
    end
  end

  // Read request capture on every accepted read address
  always_ff @(posedge clk) begin
    if (rd_acc) begin
      rd_addr_q <= s_rdaddr;
      rd_idx    <= rd_sel[IDXW-1:0];
    end
  end

  // Read FSM with registered handshake outputs and response data
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state      <= R_IDLE;
      s_rdaddrready <= 1'b0;
      s_rdvalid     <= 1'b0;
      s_rddata      <= '0;
      m_rdaddrvalid <= '0;
      m_rdready     <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (rd_acc) begin
            s_rdaddrready <= 1'b0;
            if (rd_mapped) begin
              rd_state      <= R_REQ;
              m_rdaddrvalid <= NTGT'(1) << rd_sel[IDXW-1:0];
            end else begin
              rd_state  <= R_RSP;
              s_rddata  <= ERRDATA;
              s_rdvalid <= 1'b1;
            end
          end else begin
            s_rdaddrready <= 1'b1;
          end
        end
        R_REQ: begin
          if (m_rdaddrready[rd_idx]) begin
            rd_state      <= R_WAIT;
            m_rdaddrvalid <= '0;
            m_rdready     <= NTGT'(1) << rd_idx;
          end else if (tmo_hit) begin
            rd_state      <= R_RSP;
            m_rdaddrvalid <= '0;
            s_rddata      <= ERRDATA;
            s_rdvalid     <= 1'b1;
          end
        end
        R_WAIT: begin
          if (m_rdvalid[rd_idx]) begin
            rd_state  <= R_RSP;
            m_rdready <= '0;
            s_rddata  <= rd_slice[rd_idx];
            s_rdvalid <= 1'b1;
          end else if (tmo_hit) begin
            rd_state  <= R_RSP;
            m_rdready <= '0;
            s_rddata  <= ERRDATA;
            s_rdvalid <= 1'b1;
          end
        end
        R_RSP: begin
          if (s_rdready) begin
            rd_state      <= R_IDLE;
            s_rdvalid     <= 1'b0;
            s_rdaddrready <= 1'b1;
          end
        end
        default: begin
          rd_state      <= R_IDLE;
          s_rdaddrready <= 1'b0;
          s_rdvalid     <= 1'b0;
          m_rdaddrvalid <= '0;
          m_rdready     <= '0;
        end
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle survives the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      err_status <= '0;
    end else begin
      err_status[ERR_DEC] <= (err_status[ERR_DEC] & ~err_clr) | dec_err;
      err_status[ERR_TMO] <= (err_status[ERR_TMO] & ~err_clr) | tmo_hit;
    end
  end

endmodule

// File: tb/tb_otl_trx_router.sv
// Scoreboard bench for otl_trx_router: stimulus pushes expected target writes
// and read responses; a negedge monitor pops and compares on each handshake.
module tb_otl_trx_router;

  localparam int ADDRW = 12;
  localparam int DATAW = 32;
  localparam int NTGT  = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [DATAW-1:0]      s_wrdata;
  logic [ADDRW-1:0]      s_wraddr;
  logic                  s_wrvalid;
  logic                  s_wrready;
  logic [ADDRW-1:0]      s_rdaddr;
  logic                  s_rdaddrvalid;
  logic                  s_rdaddrready;
  logic [DATAW-1:0]      s_rddata;
  logic                  s_rdvalid;
  logic                  s_rdready;
  logic [NTGT*DATAW-1:0] m_wrdata;
  logic [NTGT*ADDRW-1:0] m_wraddr;
  logic [NTGT-1:0]       m_wrvalid;
  logic [NTGT-1:0]       m_wrready;
  logic [NTGT*ADDRW-1:0] m_rdaddr;
  logic [NTGT-1:0]       m_rdaddrvalid;
  logic [NTGT-1:0]       m_rdaddrready;
  logic [NTGT*DATAW-1:0] m_rddata;
  logic [NTGT-1:0]       m_rdvalid;
  logic [NTGT-1:0]       m_rdready;
  logic [1:0]            err_status;
  logic                  err_clr;

  logic [DATAW-1:0] tgt_rdata [NTGT];

  for (genvar g = 0; g < NTGT; g++) begin : g_rd
    assign m_rddata[g*DATAW +: DATAW] = tgt_rdata[g];
  end

  otl_trx_router #(
    .ADDRW  (ADDRW),
    .DATAW  (DATAW),
    .NTGT   (NTGT),
    .SELLSB (9),
    .SELW   (3),
    .TIMEOUT(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_wrdata     (s_wrdata),
    .s_wraddr     (s_wraddr),
    .s_wrvalid    (s_wrvalid),
    .s_wrready    (s_wrready),
    .s_rdaddr     (s_rdaddr),
    .s_rdaddrvalid(s_rdaddrvalid),
    .s_rdaddrready(s_rdaddrready),
    .s_rddata     (s_rddata),
    .s_rdvalid    (s_rdvalid),
    .s_rdready    (s_rdready),
    .m_wrdata     (m_wrdata),
    .m_wraddr     (m_wraddr),
    .m_wrvalid    (m_wrvalid),
    .m_wrready    (m_wrready),
    .m_rdaddr     (m_rdaddr),
    .m_rdaddrvalid(m_rdaddrvalid),
    .m_rdaddrready(m_rdaddrready),
    .m_rddata     (m_rddata),
    .m_rdvalid    (m_rdvalid),
    .m_rdready    (m_rdready),
    .err_status   (err_status),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int               tgt;
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] data;
  } wr_t;

  wr_t              wr_q[$];
  logic [DATAW-1:0] rd_q[$];
  wr_t              mon_wr;
  logic [DATAW-1:0] mon_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare on every target write and core read handshake
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NTGT; i++) begin
        if (m_wrvalid[i] && m_wrready[i]) begin
          if (wr_q.size() == 0) begin
            check("wr_unexpected_tgt", 64'(i), 64'hFFFF);
          end else begin
            mon_wr = wr_q.pop_front();
            check("wr_tgt", 64'(i), 64'(mon_wr.tgt));
            check("wr_addr", 64'(ADDRW'(m_wraddr >> (i*ADDRW))), 64'(mon_wr.addr));
            check("wr_data", 64'(DATAW'(m_wrdata >> (i*DATAW))), 64'(mon_wr.data));
          end
        end
      end
      if (s_rdvalid && s_rdready) begin
        if (rd_q.size() == 0) begin
          check("rd_unexpected", 64'(s_rddata), 64'hFFFF_FFFF_FFFF);
        end else begin
          mon_rd = rd_q.pop_front();
          check("rd_data", 64'(s_rddata), 64'(mon_rd));
        end
      end
    end
  end

  task automatic send_wr(input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d, output int acc_cyc);
    int n = 0;
    s_wraddr  = a;
    s_wrdata  = d;
    s_wrvalid = 1'b1;
    while (!s_wrready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("wr_accept_bound", 64'(s_wrready), 64'd1);
    tick();
    acc_cyc   = cyc;
    s_wrvalid = 1'b0;
  endtask

  task automatic send_rd(input logic [ADDRW-1:0] a);
    int n = 0;
    s_rdaddr      = a;
    s_rdaddrvalid = 1'b1;
    while (!s_rdaddrready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("rd_accept_bound", 64'(s_rdaddrready), 64'd1);
    tick();
    s_rdaddrvalid = 1'b0;
  endtask

  task automatic respond_rd(input int t, input logic [DATAW-1:0] d);
    int n = 0;
    while (!m_rdready[t] && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("rd_tgt_ready_bound", 64'(m_rdready), 64'(1 << t));
    tgt_rdata[t] = d;
    m_rdvalid[t] = 1'b1;
    tick();
    m_rdvalid[t] = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    s_rdready = 1'b1;
    while (!s_rdvalid && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("rd_rsp_bound", 64'(s_rdvalid), 64'd1);
    tick();
    s_rdready = 1'b0;
  endtask

  initial begin
    int c0, c1, n;
    reset = 1'b1;
    s_wrdata = '0; s_wraddr = '0; s_wrvalid = 1'b0;
    s_rdaddr = '0; s_rdaddrvalid = 1'b0; s_rdready = 1'b0;
    m_wrready = '0; m_rdaddrready = '0; m_rdvalid = '0;
    err_clr = 1'b0;
    for (int i = 0; i < NTGT; i++) tgt_rdata[i] = '0;

    // Reset state, during and on the first cycle after reset
    tick(); tick(); tick();
    check("rst_wrready", 64'(s_wrready), 64'd0);
    check("rst_rdaddrready", 64'(s_rdaddrready), 64'd0);
    check("rst_rdvalid", 64'(s_rdvalid), 64'd0);
    check("rst_rddata", 64'(s_rddata), 64'd0);
    check("rst_m_valids", 64'({m_wrvalid, m_rdaddrvalid, m_rdready}), 64'd0);
    check("rst_err", 64'(err_status), 64'd0);
    reset = 1'b0;
    check("post_rst_wrready", 64'(s_wrready), 64'd0);
    check("post_rst_rdaddrready", 64'(s_rdaddrready), 64'd0);
    tick();
    check("idle_wrready", 64'(s_wrready), 64'd1);
    check("idle_rdaddrready", 64'(s_rdaddrready), 64'd1);

    // Write to sel 2 with the target stalling three cycles
    wr_q.push_back('{2, 12'h400, 32'h1234_5678});
    send_wr(12'h400, 32'h1234_5678, c0);
    for (int k = 0; k < 4; k++) begin
      check("w1_m_wrvalid", 64'(m_wrvalid), 64'h4);
      check("w1_wrready_low", 64'(s_wrready), 64'd0);
      check("w1_addr_stable", 64'(ADDRW'(m_wraddr >> (2*ADDRW))), 64'h400);
      if (k == 3) m_wrready = 4'b0100;
      tick();
    end
    m_wrready = '0;
    check("w1_done_valid", 64'(m_wrvalid), 64'd0);
    check("w1_done_ready", 64'(s_wrready), 64'd1);

    // Read from sel 1, data two cycles after address handshake, core stalls
    rd_q.push_back(32'hA5A5_0001);
    m_rdaddrready = 4'b0010;
    send_rd(12'h200);
    check("r1_addrvalid", 64'(m_rdaddrvalid), 64'h2);
    check("r1_rdaddr", 64'(ADDRW'(m_rdaddr >> ADDRW)), 64'h200);
    tick();
    check("r1_m_rdready", 64'(m_rdready), 64'h2);
    check("r1_addrvalid_drop", 64'(m_rdaddrvalid), 64'd0);
    m_rdaddrready = '0;
    tick();
    tgt_rdata[1] = 32'hA5A5_0001;
    m_rdvalid[1] = 1'b1;
    tick();
    m_rdvalid[1] = 1'b0;
    tgt_rdata[1] = 32'h0;
    check("r1_rdvalid", 64'(s_rdvalid), 64'd1);
    check("r1_m_rdready_drop", 64'(m_rdready), 64'd0);
    for (int k = 0; k < 2; k++) begin
      check("r1_rddata_stable", 64'(s_rddata), 64'hA5A5_0001);
      tick();
    end
    s_rdready = 1'b1;
    tick();
    s_rdready = 1'b0;
    check("r1_rdvalid_drop", 64'(s_rdvalid), 64'd0);

    // Unmapped read to sel 7: local error response, no target activity
    rd_q.push_back(32'hDEAD_BEEF);
    send_rd(12'hE00);
    check("r_unmap_rdvalid", 64'(s_rdvalid), 64'd1);
    check("r_unmap_data", 64'(s_rddata), 64'hDEAD_BEEF);
    check("r_unmap_err", 64'(err_status), 64'h1);
    check("r_unmap_no_m", 64'({m_wrvalid, m_rdaddrvalid, m_rdready}), 64'd0);
    s_rdready = 1'b1;
    tick();
    s_rdready = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", 64'(err_status), 64'd0);

    // Unmapped write is dropped; then an error coinciding with clear wins
    send_wr(12'hC00, 32'h0BAD_0BAD, c0);
    check("w_unmap_err", 64'(err_status), 64'h1);
    check("w_unmap_no_m", 64'(m_wrvalid), 64'd0);
    check("w_unmap_ready", 64'(s_wrready), 64'd1);
    err_clr = 1'b1;
    send_wr(12'hC00, 32'h0BAD_0BAD, c0);
    err_clr = 1'b0;
    check("err_set_wins", 64'(err_status), 64'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared2", 64'(err_status), 64'd0);

    // Unresponsive target on sel 0
`ifdef OTL_TRX_ROUTER_TIMEOUT_EN
    rd_q.push_back(32'hDEAD_BEEF);
    send_rd(12'h000);
    n = 0;
    while (!s_rdvalid && n < 20) begin
      tick();
      n++;
    end
    check("tmo_latency", 64'(n), 64'd8);
    check("tmo_data", 64'(s_rddata), 64'hDEAD_BEEF);
    check("tmo_err", 64'(err_status), 64'h2);
    check("tmo_no_m", 64'({m_rdaddrvalid, m_rdready}), 64'd0);
    s_rdready = 1'b1;
    tick();
    s_rdready = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
`else
    rd_q.push_back(32'h0000_0C0C);
    send_rd(12'h000);
    n = 0;
    while (!s_rdvalid && n < 12) begin
      tick();
      n++;
    end
    check("no_tmo_rdvalid", 64'(s_rdvalid), 64'd0);
    check("no_tmo_addrvalid", 64'(m_rdaddrvalid), 64'h1);
    check("no_tmo_err", 64'(err_status), 64'd0);
    m_rdaddrready = 4'b0001;
    respond_rd(0, 32'h0000_0C0C);
    m_rdaddrready = '0;
    wait_rsp();
`endif

    // Back-to-back writes to sel 0 and sel 3 alongside a read of sel 0
    m_wrready     = 4'b1111;
    m_rdaddrready = 4'b0001;
    wr_q.push_back('{0, 12'h010, 32'h1111_0000});
    wr_q.push_back('{3, 12'h610, 32'h3333_0003});
    rd_q.push_back(32'h0000_00A0);
    fork
      begin
        send_wr(12'h010, 32'h1111_0000, c0);
        send_wr(12'h610, 32'h3333_0003, c1);
        check("wr_b2b_spacing", 64'(c1 - c0), 64'd2);
      end
      begin
        send_rd(12'h020);
        respond_rd(0, 32'h0000_00A0);
        wait_rsp();
      end
    join
    tick();
    m_wrready     = '0;
    m_rdaddrready = '0;

    // Reset while in R_WAIT, then a fresh read
    m_rdaddrready = 4'b0010;
    send_rd(12'h200);
    tick();
    check("rw_m_rdready", 64'(m_rdready), 64'h2);
    m_rdaddrready = '0;
    reset = 1'b1;
    tick();
    check("rw_rst_valids", 64'({m_wrvalid, m_rdaddrvalid, m_rdready, s_rdvalid}), 64'd0);
    check("rw_rst_ready", 64'(s_rdaddrready), 64'd0);
    reset = 1'b0;
    rd_q.push_back(32'hBEEF_0002);
    m_rdaddrready = 4'b0010;
    send_rd(12'h2A4);
    check("rw_fresh_addrvalid", 64'(m_rdaddrvalid), 64'h2);
    respond_rd(1, 32'hBEEF_0002);
    m_rdaddrready = '0;
    wait_rsp();

    tick(); tick();
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
